// File: rtl/rr_arbiter.sv
// rr_arbiter: N-port round-robin arbiter with optional grant locking.
//
// Produces a registered one-hot grant, the binary index of the grantee
// (select) and an active flag. The select register doubles as the
// round-robin pointer: every search starts one port past the last grantee.
//
// Build option:
//   ARBITER_LOCK_EN  defined   -> a grantee keeps its grant for as long as
//                                  it holds its request line high.
//                    undefined -> no lock; the search restarts every cycle
//                                  at (select+1), so continuously requesting
//                                  ports rotate one grant per cycle.
//
// Handshake: request[i] is a level. A port owns the resource in every cycle
// where grant[i] is high. With locking, the owner gives the resource up by
// dropping request[i]; the hand-off to the next requester happens at that
// same edge, with no idle cycle in between.
module rr_arbiter #(
    parameter int NUM_PORTS = 9
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_PORTS-1:0]         request,
    output logic [NUM_PORTS-1:0]         grant,
    output logic [$clog2(NUM_PORTS)-1:0] select,
    output logic                         active
);

    localparam int SEL_W = $clog2(NUM_PORTS);

    // Result of the cyclic search over request.
    logic             search_found;
    logic [SEL_W-1:0] search_idx;

    // Current grantee still wants the resource and may keep it.
    logic             lock_hit;

    // Next-state values for the output registers.
    logic [NUM_PORTS-1:0] grant_nxt;
    logic [SEL_W-1:0]     select_nxt;
    logic                 active_nxt;

    // Cyclic priority search: start at select+1, wrap, end at select itself.
    // The first set request bit in that order wins. Ending on select means a
    // lone requester that already holds the pointer can still be granted.
    always_comb begin
        int               idx;
        logic [SEL_W-1:0] idx_s;
        search_found = 1'b0;
        search_idx   = select;
        idx          = 0;
        idx_s        = '0;
        for (int off = 1; off <= NUM_PORTS; off++) begin
            idx = int'(select) + off;
            if (idx >= NUM_PORTS) begin
                idx = idx - NUM_PORTS;
            end
            idx_s = SEL_W'(idx);
            if (!search_found && request[idx_s]) begin
                search_found = 1'b1;
                search_idx   = idx_s;
            end
        end
    end

`ifdef ARBITER_LOCK_EN
    // Lock holds only while a grant is outstanding and its owner still requests.
    assign lock_hit = (|grant) && request[select];
`else
    // Without locking the grant is re-arbitrated on every clock.
    assign lock_hit = 1'b0;
`endif

    // Next grant: keep a locked tenure, else take the search winner, else go idle.
    always_comb begin
        grant_nxt  = '0;
        select_nxt = select;
        active_nxt = 1'b0;
        if (lock_hit) begin
            grant_nxt  = grant;
            select_nxt = select;
            active_nxt = active;
        end else if (search_found) begin
            grant_nxt             = '0;
            grant_nxt[search_idx] = 1'b1;
            select_nxt            = search_idx;
            active_nxt            = 1'b1;
        end else begin
            // Idle: the pointer keeps the last grantee so fairness survives gaps.
            grant_nxt  = '0;
            select_nxt = select;
            active_nxt = 1'b0;
        end
    end

    // Output registers; asynchronous active-low reset clears everything and
    // returns the pointer to port 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant  <= '0;
            select <= '0;
            active <= 1'b0;
        end else begin
            grant  <= grant_nxt;
            select <= select_nxt;
            active <= active_nxt;
        end
    end

endmodule

// File: tb/tb_rr_arbiter.sv
// tb_rr_arbiter: directed bench for rr_arbiter with NUM_PORTS=9.
// Expected grantee sequences are hand-derived for both build flavours
// (ARBITER_LOCK_EN defined or not).
module tb_rr_arbiter;

  localparam int N  = 9;
  localparam int SW = $clog2(N);

`ifdef ARBITER_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [N-1:0]  request = '0;
  logic [N-1:0]  grant;
  logic [SW-1:0] select;
  logic          active;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  rr_arbiter #(.NUM_PORTS(N)) dut (
    .clk     (clk),
    .rst     (rst),
    .request (request),
    .grant   (grant),
    .select  (select),
    .active  (active)
  );

  // ---------------- driver helpers ----------------
  // Advance one clock and settle just after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst     = 1'b0;
    request = '0;
    for (int i = 0; i < 10; i++) begin
      step();
      vec_cnt++;
      if (grant !== '0 || select !== '0 || active !== 1'b0) begin
        err_cnt++;
        $display("FAIL reset_hold cyc %0d: grant=%b select=%0d active=%b, expected 0/0/0",
                 i, grant, select, active);
      end
    end
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      vec_cnt++;
      if (grant !== '0 || select !== '0 || active !== 1'b0) begin
        err_cnt++;
        $display("FAIL reset_idle cyc %0d: grant=%b select=%0d active=%b, expected 0/0/0",
                 i, grant, select, active);
      end
    end
  endtask

  task automatic test_basic_lock();
    logic [N-1:0] exp_g;
    int           exp_s;
    request = 9'b100000001;
    for (int i = 0; i < 15; i++) begin
      step();
      // Lock: port 8 held. No lock: 8 and 0 alternate.
      exp_s = LOCK_EN ? 8 : ((i % 2 == 0) ? 8 : 0);
      exp_g = N'(1) << exp_s;
      vec_cnt++;
      if (grant !== exp_g || select !== SW'(exp_s) || active !== 1'b1) begin
        err_cnt++;
        $display("FAIL basic_lock cyc %0d: grant=%b select=%0d active=%b, expected grant=%b select=%0d active=1",
                 i, grant, select, active, exp_g, exp_s);
      end
    end
    request = 9'b000000010;
    step();
    vec_cnt++;
    if (grant !== 9'b000000010 || select !== SW'(1) || active !== 1'b1) begin
      err_cnt++;
      $display("FAIL basic_release: grant=%b select=%0d active=%b, expected grant=000000010 select=1 active=1",
               grant, select, active);
    end
  endtask

  task automatic test_round_robin();
    int           seq_l[3] = '{7, 7, 7};
    int           seq_n[3] = '{7, 0, 7};
    int           hold_l[4] = '{0, 0, 0, 0};
    int           hold_n[4] = '{7, 0, 7, 0};
    logic [N-1:0] exp_g;
    int           exp_s;
    request = 9'b010000001;
    for (int i = 0; i < 3; i++) begin
      step();
      exp_s = LOCK_EN ? seq_l[i] : seq_n[i];
      exp_g = N'(1) << exp_s;
      vec_cnt++;
      if (grant !== exp_g || select !== SW'(exp_s) || active !== 1'b1) begin
        err_cnt++;
        $display("FAIL rr_order cyc %0d: grant=%b select=%0d active=%b, expected grant=%b select=%0d active=1",
                 i, grant, select, active, exp_g, exp_s);
      end
    end
    request = 9'b000000001;
    step();
    vec_cnt++;
    if (grant !== 9'b000000001 || select !== SW'(0) || active !== 1'b1) begin
      err_cnt++;
      $display("FAIL rr_wrap: grant=%b select=%0d active=%b, expected grant=000000001 select=0 active=1",
               grant, select, active);
    end
    request = 9'b010000001;
    for (int i = 0; i < 4; i++) begin
      step();
      exp_s = LOCK_EN ? hold_l[i] : hold_n[i];
      exp_g = N'(1) << exp_s;
      vec_cnt++;
      if (grant !== exp_g || select !== SW'(exp_s) || active !== 1'b1) begin
        err_cnt++;
        $display("FAIL rr_no_preempt cyc %0d: grant=%b select=%0d active=%b, expected grant=%b select=%0d active=1",
                 i, grant, select, active, exp_g, exp_s);
      end
    end
  endtask

  task automatic test_idle_gap();
    request = 9'b000100000;
    step();
    vec_cnt++;
    if (grant !== 9'b000100000 || select !== SW'(5) || active !== 1'b1) begin
      err_cnt++;
      $display("FAIL idle_first: grant=%b select=%0d active=%b, expected grant=000100000 select=5 active=1",
               grant, select, active);
    end
    request = '0;
    step();
    vec_cnt++;
    if (grant !== '0 || select !== SW'(5) || active !== 1'b0) begin
      err_cnt++;
      $display("FAIL idle_gap: grant=%b select=%0d active=%b, expected grant=0 select=5 active=0",
               grant, select, active);
    end
    request = 9'b000100000;
    for (int i = 0; i < 2; i++) begin
      step();
      vec_cnt++;
      if (grant !== 9'b000100000 || select !== SW'(5) || active !== 1'b1) begin
        err_cnt++;
        $display("FAIL idle_regrant cyc %0d: grant=%b select=%0d active=%b, expected grant=000100000 select=5 active=1",
                 i, grant, select, active);
      end
    end
  endtask

  task automatic test_fairness();
    int           pre_l[2]  = '{5, 5};
    int           pre_n[2]  = '{6, 7};
    int           post_l[3] = '{6, 6, 6};
    int           post_n[3] = '{0, 1, 2};
    logic [N-1:0] exp_g;
    int           exp_s;
    request = 9'b111111111;
    for (int i = 0; i < 2; i++) begin
      step();
      exp_s = LOCK_EN ? pre_l[i] : pre_n[i];
      exp_g = N'(1) << exp_s;
      vec_cnt++;
      if (grant !== exp_g || select !== SW'(exp_s) || active !== 1'b1) begin
        err_cnt++;
        $display("FAIL fair_all cyc %0d: grant=%b select=%0d active=%b, expected grant=%b select=%0d active=1",
                 i, grant, select, active, exp_g, exp_s);
      end
    end
    request = 9'b111011111;
    step();
    exp_s = LOCK_EN ? 6 : 8;
    exp_g = N'(1) << exp_s;
    vec_cnt++;
    if (grant !== exp_g || select !== SW'(exp_s) || active !== 1'b1) begin
      err_cnt++;
      $display("FAIL fair_handoff: grant=%b select=%0d active=%b, expected grant=%b select=%0d active=1",
               grant, select, active, exp_g, exp_s);
    end
    request = 9'b111111111;
    for (int i = 0; i < 3; i++) begin
      step();
      exp_s = LOCK_EN ? post_l[i] : post_n[i];
      exp_g = N'(1) << exp_s;
      vec_cnt++;
      if (grant !== exp_g || select !== SW'(exp_s) || active !== 1'b1) begin
        err_cnt++;
        $display("FAIL fair_hold cyc %0d: grant=%b select=%0d active=%b, expected grant=%b select=%0d active=1",
                 i, grant, select, active, exp_g, exp_s);
      end
    end
  endtask

  task automatic test_reset_mid_tenure();
    // Assert reset between clock edges while a grant is outstanding.
    rst = 1'b0;
    #1;
    vec_cnt++;
    if (grant !== '0 || select !== '0 || active !== 1'b0) begin
      err_cnt++;
      $display("FAIL async_reset: grant=%b select=%0d active=%b, expected 0/0/0",
               grant, select, active);
    end
    for (int i = 0; i < 2; i++) begin
      step();
      vec_cnt++;
      if (grant !== '0 || select !== '0 || active !== 1'b0) begin
        err_cnt++;
        $display("FAIL reset_held cyc %0d: grant=%b select=%0d active=%b, expected 0/0/0",
                 i, grant, select, active);
      end
    end
    request = '0;
    rst     = 1'b1;
    step();
    vec_cnt++;
    if (grant !== '0 || select !== '0 || active !== 1'b0) begin
      err_cnt++;
      $display("FAIL reset_release: grant=%b select=%0d active=%b, expected 0/0/0",
               grant, select, active);
    end
    // Lone request on port 0: the search from port 1 wraps back to 0.
    request = 9'b000000001;
    step();
    vec_cnt++;
    if (grant !== 9'b000000001 || select !== SW'(0) || active !== 1'b1) begin
      err_cnt++;
      $display("FAIL port0_alone: grant=%b select=%0d active=%b, expected grant=000000001 select=0 active=1",
               grant, select, active);
    end
    request = '0;
    step();
    vec_cnt++;
    if (grant !== '0 || select !== SW'(0) || active !== 1'b0) begin
      err_cnt++;
      $display("FAIL port0_release: grant=%b select=%0d active=%b, expected grant=0 select=0 active=0",
               grant, select, active);
    end
  endtask

  task automatic test_rotation();
    logic [N-1:0] exp_g;
    int           exp_s;
    request = 9'b111111111;
    for (int i = 0; i < 12; i++) begin
      step();
      // Lock: port 1 wins and keeps it. No lock: 1,2,...,8,0,1,...
      exp_s = LOCK_EN ? 1 : ((i + 1) % N);
      exp_g = N'(1) << exp_s;
      vec_cnt++;
      if (grant !== exp_g || select !== SW'(exp_s) || active !== 1'b1) begin
        err_cnt++;
        $display("FAIL rotation cyc %0d: grant=%b select=%0d active=%b, expected grant=%b select=%0d active=1",
                 i, grant, select, active, exp_g, exp_s);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] req_v[5]  = '{9'b111111101, 9'b111111111, 9'b111111111, 9'b111111011, 9'b111111111};
    int           exp_l[5]  = '{2, 2, 2, 3, 3};
    int           exp_n[5]  = '{4, 5, 6, 7, 8};
    logic [N-1:0] exp_g;
    int           exp_s;
    for (int i = 0; i < 5; i++) begin
      request = req_v[i];
      step();
      exp_s = LOCK_EN ? exp_l[i] : exp_n[i];
      exp_g = N'(1) << exp_s;
      vec_cnt++;
      if (grant !== exp_g || select !== SW'(exp_s) || active !== 1'b1) begin
        err_cnt++;
        $display("FAIL back_to_back cyc %0d: grant=%b select=%0d active=%b, expected grant=%b select=%0d active=1",
                 i, grant, select, active, exp_g, exp_s);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic_lock();
    test_round_robin();
    test_idle_gap();
    test_fairness();
    test_reset_mid_tenure();
    test_rotation();
    test_back_to_back();
    request = '0;
    step();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  // Time limit so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, vectors=%0d miscompares=%0d", vec_cnt, err_cnt);
    $fatal(1, "time limit");
  end

endmodule
